// File: rtl/conv_feeder_pkg.sv
// Shared types and sizing helpers for the convolution feeder.
package conv_feeder_pkg;

    typedef enum logic [1:0] {StIdle, StStart, StStream, StDone} state_e;

    // Values for the default 27x27 / pad 2 / 5x5 configuration.
    localparam int unsigned DefaultPadSide    = 31;
    localparam int unsigned DefaultKernelArea = 25;

    function automatic int unsigned padded_side(int unsigned ifm_size, int unsigned pad);
        return ifm_size + 2 * pad;
    endfunction

    function automatic int unsigned kernel_area(int unsigned k);
        return k * k;
    endfunction

    // Bits needed to hold the values 0..max_val inclusive.
    function automatic int unsigned cnt_width(int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/conv_feeder_addr_gen.sv
// Pass/position counters, pad detection and memory address generation for conv_feeder.
module conv_feeder_addr_gen
    import conv_feeder_pkg::*;
#(
    parameter int unsigned IFM_SIZE    = 27,
    parameter int unsigned KERNEL_SIZE = 5,
    parameter int unsigned PAD         = 2,
    parameter int unsigned CI          = 3,
    parameter int unsigned CO          = 8,
    parameter int unsigned ADDR_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_i,
    input  logic                  ifm_adv_i,
    input  logic                  wgt_adv_i,
    output logic                  ifm_left_o,
    output logic                  wgt_left_o,
    output logic                  ifm_pad_o,
    output logic [ADDR_WIDTH-1:0] ifm_addr_o,
    output logic [ADDR_WIDTH-1:0] wgt_addr_o,
    output logic                  pass_end_o,
    output logic                  last_pass_o
);

    localparam int unsigned P    = padded_side(IFM_SIZE, PAD);
    localparam int unsigned KK   = kernel_area(KERNEL_SIZE);
    localparam int unsigned PosW = cnt_width(P);
    localparam int unsigned KW   = cnt_width(KK);
    localparam int unsigned CiW  = cnt_width(CI);
    localparam int unsigned CoW  = cnt_width(CO);

    logic [PosW-1:0] row_q, row_d, col_q, col_d;
    logic [KW-1:0]   k_q, k_d;
    logic [CiW-1:0]  ci_q, ci_d;
    logic [CoW-1:0]  co_q, co_d;
    logic            ifm_last, wgt_last;

    // row_q == P marks the ifm side of the pass as exhausted.
    assign ifm_left_o = row_q < PosW'(P);
    assign wgt_left_o = k_q < KW'(KK);

    assign ifm_last = !ifm_left_o ||
                      (ifm_adv_i && row_q == PosW'(P - 1) && col_q == PosW'(P - 1));
    assign wgt_last = !wgt_left_o || (wgt_adv_i && k_q == KW'(KK - 1));

    assign pass_end_o  = ifm_last && wgt_last && (ifm_adv_i || wgt_adv_i);
    assign last_pass_o = (ci_q == CiW'(CI - 1)) && (co_q == CoW'(CO - 1));

    assign ifm_pad_o = (row_q < PosW'(PAD)) || (row_q >= PosW'(PAD + IFM_SIZE)) ||
                       (col_q < PosW'(PAD)) || (col_q >= PosW'(PAD + IFM_SIZE));

    assign wgt_addr_o = (ADDR_WIDTH'(co_q) * ADDR_WIDTH'(CI) + ADDR_WIDTH'(ci_q)) *
                        ADDR_WIDTH'(KK) + ADDR_WIDTH'(k_q);

    assign ifm_addr_o = ADDR_WIDTH'(ci_q) * ADDR_WIDTH'(IFM_SIZE * IFM_SIZE) +
                        (ADDR_WIDTH'(row_q) - ADDR_WIDTH'(PAD)) * ADDR_WIDTH'(IFM_SIZE) +
                        ADDR_WIDTH'(col_q) - ADDR_WIDTH'(PAD);

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        k_d   = k_q;
        ci_d  = ci_q;
        co_d  = co_q;
        if (clear_i) begin
            row_d = '0;
            col_d = '0;
            k_d   = '0;
            ci_d  = '0;
            co_d  = '0;
        end else if (pass_end_o) begin
            row_d = '0;
            col_d = '0;
            k_d   = '0;
            if (ci_q == CiW'(CI - 1)) begin
                ci_d = '0;
                co_d = (co_q == CoW'(CO - 1)) ? '0 : co_q + CoW'(1);
            end else begin
                ci_d = ci_q + CiW'(1);
            end
        end else begin
            if (ifm_adv_i) begin
                if (col_q == PosW'(P - 1)) begin
                    col_d = '0;
                    row_d = row_q + PosW'(1);
                end else begin
                    col_d = col_q + PosW'(1);
                end
            end
            if (wgt_adv_i) begin
                k_d = k_q + KW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
            k_q   <= '0;
            ci_q  <= '0;
            co_q  <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
            k_q   <= k_d;
            ci_q  <= ci_d;
            co_q  <= co_d;
        end
    end

endmodule

// File: rtl/conv_feeder.sv
// Layer feeder: streams padded ifm words and kernel weights to a convolution consumer on request.
module conv_feeder
    import conv_feeder_pkg::*;
#(
    parameter int unsigned IFM_WIDTH    = 16,
    parameter int unsigned WEIGHT_WIDTH = 16,
    parameter int unsigned IFM_SIZE     = 27,
    parameter int unsigned KERNEL_SIZE  = 5,
    parameter int unsigned PAD          = 2,
    parameter int unsigned CI           = 3,
    parameter int unsigned CO           = 8,
    parameter int unsigned ADDR_WIDTH   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic                    ifm_read_i,
    input  logic                    wgt_read_i,
    output logic                    start_conv_o,
    output logic                    in_valid_o,
    output logic [IFM_WIDTH-1:0]    ifm_o,
    output logic [WEIGHT_WIDTH-1:0] wgt_o,
    output logic                    ifm_mem_rd_o,
    output logic [ADDR_WIDTH-1:0]   ifm_mem_addr_o,
    input  logic [IFM_WIDTH-1:0]    ifm_mem_data_i,
    output logic                    wgt_mem_rd_o,
    output logic [ADDR_WIDTH-1:0]   wgt_mem_addr_o,
    input  logic [WEIGHT_WIDTH-1:0] wgt_mem_data_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    overrun_o
);

    state_e state_q;
    logic   start_conv_q, busy_q, done_q, overrun_q;
    logic   in_valid_q, ifm_sel_q, wgt_sel_q;
    logic   launch, streaming, ifm_acc, wgt_acc;
    logic   ifm_left, wgt_left, ifm_pad, pass_end, last_pass;
    logic [ADDR_WIDTH-1:0] ifm_addr, wgt_addr;

    assign launch    = (state_q == StIdle) && start_i;
    assign streaming = (state_q == StStream);
    assign ifm_acc   = streaming && ifm_read_i && ifm_left;
    assign wgt_acc   = streaming && wgt_read_i && wgt_left;

    // Pad positions consume a slot but never touch memory.
    assign ifm_mem_rd_o   = ifm_acc && !ifm_pad;
    assign ifm_mem_addr_o = ifm_mem_rd_o ? ifm_addr : '0;
    assign wgt_mem_rd_o   = wgt_acc;
    assign wgt_mem_addr_o = wgt_acc ? wgt_addr : '0;

    conv_feeder_addr_gen #(
        .IFM_SIZE    (IFM_SIZE),
        .KERNEL_SIZE (KERNEL_SIZE),
        .PAD         (PAD),
        .CI          (CI),
        .CO          (CO),
        .ADDR_WIDTH  (ADDR_WIDTH)
    ) u_addr_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (launch),
        .ifm_adv_i   (ifm_acc),
        .wgt_adv_i   (wgt_acc),
        .ifm_left_o  (ifm_left),
        .wgt_left_o  (wgt_left),
        .ifm_pad_o   (ifm_pad),
        .ifm_addr_o  (ifm_addr),
        .wgt_addr_o  (wgt_addr),
        .pass_end_o  (pass_end),
        .last_pass_o (last_pass)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            start_conv_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_q      <= StStart;
                        start_conv_q <= 1'b1;
                        busy_q       <= 1'b1;
                    end
                end
                StStart: begin
                    state_q      <= StStream;
                    start_conv_q <= 1'b0;
                end
                StStream: begin
                    if (pass_end && last_pass) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_valid_q <= 1'b0;
            ifm_sel_q  <= 1'b0;
            wgt_sel_q  <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            in_valid_q <= ifm_acc || wgt_acc;
            ifm_sel_q  <= ifm_mem_rd_o;
            wgt_sel_q  <= wgt_acc;
            if (launch) begin
                overrun_q <= 1'b0;
            end else if ((ifm_read_i && !ifm_acc) || (wgt_read_i && !wgt_acc)) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign start_conv_o = start_conv_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign overrun_o    = overrun_q;
    assign in_valid_o   = in_valid_q;
    assign ifm_o        = ifm_sel_q ? ifm_mem_data_i : '0;
    assign wgt_o        = wgt_sel_q ? wgt_mem_data_i : '0;

endmodule

// File: doc/conv_feeder.md
CONV_FEEDER -- requirements
Module: conv_feeder

Interface
REQ-001 Parameter IFM_WIDTH, 16, ifm word width.
REQ-002 Parameter WEIGHT_WIDTH, 16, weight word width.
REQ-003 Parameter IFM_SIZE, 27, unpadded square input side.
REQ-004 Parameter KERNEL_SIZE, 5, square kernel side.
REQ-005 Parameter PAD, 2, zero border per side; padded side P = IFM_SIZE+2*PAD.
REQ-006 Parameter CI, 3, input channels; CO, 8, output channels.
REQ-007 Parameter ADDR_WIDTH, 16, memory address width.
REQ-008 clk  in  1  single clock; all logic is on its rising edge.
REQ-009 rst_n  in  1  reset, asynchronous and active-low.
REQ-010 start  in  1  one-cycle pulse; begins a full layer feed.
REQ-011 ifm_read  in  1  consumer request for one ifm word.
REQ-012 wgt_read  in  1  consumer request for one weight word.
REQ-013 start_conv  out  1  one-cycle pulse to the consumer at layer begin.
REQ-014 in_valid  out  1  data on ifm/wgt valid this cycle.
REQ-015 ifm  out  IFM_WIDTH  ifm word, zero for pad positions.
REQ-016 wgt  out  WEIGHT_WIDTH  weight word.
REQ-017 ifm_mem_rd / ifm_mem_addr  out  1 / ADDR_WIDTH  ifm memory read strobe/address.
REQ-018 ifm_mem_data  in  IFM_WIDTH  ifm memory data, valid the cycle after ifm_mem_rd.
REQ-019 wgt_mem_rd / wgt_mem_addr  out  1 / ADDR_WIDTH  weight memory read strobe/address.
REQ-020 wgt_mem_data  in  WEIGHT_WIDTH  weight memory data, valid the cycle after wgt_mem_rd.
REQ-021 busy, done, overrun  out  1 each  feed active; one-cycle completion pulse; sticky excess-request flag.

Function
REQ-022 FSM states IDLE, START, STREAM, DONE; IDLE->START on start, START->STREAM after exactly one cycle (start_conv high during START), STREAM->DONE when last pass completes, DONE->IDLE after one cycle (done high during DONE).
REQ-023 start outside IDLE is ignored; busy is high in START, STREAM, DONE.
REQ-024 Pass order: co outer 0..CO-1, ci inner 0..CI-1; each pass supplies K*K weights and P*P ifm words, raster order (row then col).
REQ-025 Weight address = (co*CI+ci)*K*K + k, k = 0..K*K-1.
REQ-026 Padded position (r,c): pad when r<PAD, r>=PAD+IFM_SIZE, c<PAD or c>=PAD+IFM_SIZE; else address = ci*IFM_SIZE*IFM_SIZE + (r-PAD)*IFM_SIZE + (c-PAD).
REQ-027 Request accepted in STREAM at cycle t drives mem_rd/addr combinationally at t; in_valid and data appear at t+1 (latency 1); pad positions issue no ifm_mem_rd and output 0 at t+1.
REQ-028 ifm_read and wgt_read in the same cycle are both served; single in_valid covers both at t+1; non-requested port outputs 0.
REQ-029 Back-to-back requests every cycle sustained, one word per port per cycle.
REQ-030 Pass completes when both weight and ifm counts for the pass are exhausted; counters clear and ci/co advance on that edge.
REQ-031 Request on an exhausted port within a pass, or outside STREAM, is ignored (no mem_rd, no in_valid) and sets overrun until next start.
REQ-032 Address arithmetic is unsigned, computed at ADDR_WIDTH, no wrap checking.

Reset
REQ-033 rst_n low asynchronously forces IDLE, all counters 0, all outputs 0 (overrun cleared), including mid-stream; no pending data is emitted after release.

Structure
REQ-034 Shared package holds FSM state typedef, P and K*K localparams, and address-width helper.
REQ-035 One sub-module conv_feeder_addr_gen (row/col/k/ci/co counters, pad detect, address compute); FSM and output registers in top.

Verification
REQ-036 IFM_SIZE=3,K=3,PAD=1,CI=1,CO=1: start -> start_conv pulse next cycle, busy high.
REQ-037 Same, 9 wgt_read -> addresses 0..8, in_valid one cycle after each, wgt equals memory.
REQ-038 Same, 25 ifm_read -> rows 0/4 and cols 0/4 output 0 with no ifm_mem_rd; (1,1) reads addr 0, (3,3) addr 8; then done pulse.
REQ-039 CI=2,CO=2: pass (co=1,ci=0) first weight addr 18, first interior ifm addr 0; done after 4 passes.
REQ-040 10th wgt_read in a pass -> no in_valid, overrun=1; next start clears it.
REQ-041 rst_n low mid-STREAM -> outputs 0 immediately, IDLE after release, new start restarts at addr 0.
